// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the display scan controller: default raster timing,
// counter/address widths, RGB byte-lane mapping and pipeline payload types.
package display_scan_ctrl_pkg;

    localparam int unsigned DEF_H_ACTIVE = 10;
    localparam int unsigned DEF_H_FP     = 2;
    localparam int unsigned DEF_H_SYNC   = 3;
    localparam int unsigned DEF_H_BP     = 3;
    localparam int unsigned DEF_V_ACTIVE = 10;
    localparam int unsigned DEF_V_FP     = 1;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 1;

    localparam int unsigned DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int unsigned CNT_W        = 12;
    localparam int unsigned DEF_ADDR_W   = 20;

    // Buffer word lanes: B=[7:0], G=[15:8], R=[23:16]
    localparam int unsigned LANE_W       = 8;
    localparam int unsigned RGB_W        = 3 * LANE_W;
    localparam int unsigned LANE_B_LSB   = 0;
    localparam int unsigned LANE_G_LSB   = 8;
    localparam int unsigned LANE_R_LSB   = 16;

    typedef struct packed {
        logic [LANE_W-1:0] r;
        logic [LANE_W-1:0] g;
        logic [LANE_W-1:0] b;
    } rgb_t;

    // Control bits carried alongside the pixel through the align pipeline
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic fs;
    } scan_ctl_t;

    // Assemble a buffer word from its three byte lanes
    function automatic rgb_t rgb_from_lanes(input logic [LANE_W-1:0] r,
                                            input logic [LANE_W-1:0] g,
                                            input logic [LANE_W-1:0] b);
        logic [RGB_W-1:0] w;
        w = '0;
        w[LANE_R_LSB +: LANE_W] = r;
        w[LANE_G_LSB +: LANE_W] = g;
        w[LANE_B_LSB +: LANE_W] = b;
        return rgb_t'(w);
    endfunction

endpackage

// File: rtl/display_scan_ctrl_timing.sv
// raster_timing_gen: h/v raster counters with active / sync / frame-edge decode.
// Ports:
//   i_clock, i_reset (async, active-high), i_enable (low holds counters at 0)
//   o_active_c  - current position is an active pixel
//   o_hsync_c   - position inside the hsync window
//   o_vsync_c   - position inside the vsync lines
//   o_first_c   - position is h=0, v=0
//   o_last_c    - position is the last cycle of the frame
module raster_timing_gen
    import display_scan_ctrl_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
)(
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_enable,
    output logic o_active_c,
    output logic o_hsync_c,
    output logic o_vsync_c,
    output logic o_first_c,
    output logic o_last_c
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
    localparam int unsigned HS_END  = HS_BEG + H_SYNC;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
    localparam int unsigned VS_END  = VS_BEG + V_SYNC;

    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic             w_h_wrap;
    logic             w_v_wrap;

    assign w_h_wrap = (r_h_cnt == CNT_W'(H_TOTAL - 1));
    assign w_v_wrap = (r_v_cnt == CNT_W'(V_TOTAL - 1));

    // Raster counters; disabled scan parks at the frame origin
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!i_enable) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_wrap) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + CNT_W'(1);
        end else begin
            r_h_cnt <= r_h_cnt + CNT_W'(1);
        end
    end

    assign o_active_c = (r_h_cnt < CNT_W'(H_ACTIVE)) && (r_v_cnt < CNT_W'(V_ACTIVE));
    assign o_hsync_c  = (r_h_cnt >= CNT_W'(HS_BEG)) && (r_h_cnt < CNT_W'(HS_END));
    assign o_vsync_c  = (r_v_cnt >= CNT_W'(VS_BEG)) && (r_v_cnt < CNT_W'(VS_END));
    assign o_first_c  = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign o_last_c   = w_h_wrap && w_v_wrap;

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: frame-buffer read-side scanner. Issues one read per active
// pixel, captures the returned RGB word and emits a sync-aligned pixel stream.
// Owns the double-buffer select, swapped only at frame end.
// Ports:
//   i_clock, i_reset (async, active-high), i_enable, i_swap_req
//   i_din_b/g/r        - buffer read data, one clock after o_rd_addr/o_rd_en
//   o_rd_addr, o_rd_en - buffer read request; o_rd_sel picks buffer 1 (0) / 2 (1)
//   o_swap_ack         - one-clock pulse when o_rd_sel toggles
//   o_pix_r/g/b, o_pix_de, o_hsync, o_vsync, o_frame_start - pixel stream
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned ADDR_W   = DEF_ADDR_W
)(
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_swap_req,
    input  logic [LANE_W-1:0] i_din_b,
    input  logic [LANE_W-1:0] i_din_g,
    input  logic [LANE_W-1:0] i_din_r,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_rd_en,
    output logic              o_rd_sel,
    output logic              o_swap_ack,
    output logic              o_frame_start,
    output logic [LANE_W-1:0] o_pix_r,
    output logic [LANE_W-1:0] o_pix_g,
    output logic [LANE_W-1:0] o_pix_b,
    output logic              o_pix_de,
    output logic              o_hsync,
    output logic              o_vsync
);

    logic              w_active;
    logic              w_hs;
    logic              w_vs;
    logic              w_first;
    logic              w_last;
    logic [ADDR_W-1:0] w_cur_addr;
    logic              w_swap_now;
    scan_ctl_t         w_ctl0;
    rgb_t              w_din;

    logic [ADDR_W-1:0] r_pix_addr;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_swap_pend;
    logic              r_rd_sel;
    logic              r_swap_ack;
    scan_ctl_t         r_ctl1;
    scan_ctl_t         r_ctl2;
    scan_ctl_t         r_ctl3;
    rgb_t              r_pix;

    raster_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_raster (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_enable   (i_enable),
        .o_active_c (w_active),
        .o_hsync_c  (w_hs),
        .o_vsync_c  (w_vs),
        .o_first_c  (w_first),
        .o_last_c   (w_last)
    );

    // Running pixel address equals v*H_ACTIVE+h; frame origin restarts it at 0
    assign w_cur_addr = w_first ? '0 : r_pix_addr;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_pix_addr <= '0;
            r_rd_addr  <= '0;
        end else if (!i_enable) begin
            r_pix_addr <= '0;
            r_rd_addr  <= '0;
        end else if (w_active) begin
            r_pix_addr <= w_cur_addr + ADDR_W'(1);
            r_rd_addr  <= w_cur_addr;
        end else begin
            r_rd_addr  <= '0;
        end
    end

    // A request landing on the very last frame cycle swaps without pending
    assign w_swap_now = i_enable && w_last && (r_swap_pend || i_swap_req);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_swap_pend <= 1'b0;
            r_rd_sel    <= 1'b0;
            r_swap_ack  <= 1'b0;
        end else begin
            r_swap_ack <= 1'b0;
            if (w_swap_now) begin
                r_rd_sel    <= ~r_rd_sel;
                r_swap_ack  <= 1'b1;
                r_swap_pend <= 1'b0;
            end else if (i_swap_req) begin
                r_swap_pend <= 1'b1;
            end
        end
    end

    // Stage-0 control word; everything forced low while disabled
    always_comb begin
        w_ctl0    = '0;
        w_ctl0.de = i_enable && w_active;
        w_ctl0.hs = i_enable && w_hs;
        w_ctl0.vs = i_enable && w_vs;
        w_ctl0.fs = i_enable && w_first && w_active;
    end

    assign w_din = rgb_from_lanes(i_din_r, i_din_g, i_din_b);

    // Three-stage align: read issue, buffer latency, pixel capture
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_ctl1 <= '0;
            r_ctl2 <= '0;
            r_ctl3 <= '0;
            r_pix  <= '0;
        end else begin
            r_ctl1 <= w_ctl0;
            r_ctl2 <= r_ctl1;
            r_ctl3 <= r_ctl2;
            r_pix  <= r_ctl2.de ? w_din : '0;
        end
    end

    assign o_rd_addr     = r_rd_addr;
    assign o_rd_en       = r_ctl1.de;
    assign o_rd_sel      = r_rd_sel;
    assign o_swap_ack    = r_swap_ack;
    assign o_frame_start = r_ctl3.fs;
    assign o_pix_r       = r_pix.r;
    assign o_pix_g       = r_pix.g;
    assign o_pix_b       = r_pix.b;
    assign o_pix_de      = r_ctl3.de;
    assign o_hsync       = r_ctl3.hs;
    assign o_vsync       = r_ctl3.vs;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a synchronous frame-buffer model.
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        swap_req;
    logic [7:0]  din_b = 8'h00;
    logic [7:0]  din_g = 8'h00;
    logic [7:0]  din_r = 8'h00;
    logic [19:0] rd_addr;
    logic        rd_en;
    logic        rd_sel;
    logic        swap_ack;
    logic        fs;
    logic [7:0]  pix_r;
    logic [7:0]  pix_g;
    logic [7:0]  pix_b;
    logic        pix_de;
    logic        hsync;
    logic        vsync;

    always #5 clk = ~clk;

    display_scan_ctrl dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_enable      (en),
        .i_swap_req    (swap_req),
        .i_din_b       (din_b),
        .i_din_g       (din_g),
        .i_din_r       (din_r),
        .o_rd_addr     (rd_addr),
        .o_rd_en       (rd_en),
        .o_rd_sel      (rd_sel),
        .o_swap_ack    (swap_ack),
        .o_frame_start (fs),
        .o_pix_r       (pix_r),
        .o_pix_g       (pix_g),
        .o_pix_b       (pix_b),
        .o_pix_de      (pix_de),
        .o_hsync       (hsync),
        .o_vsync       (vsync)
    );

    // Buffer returns {addr, ~addr, 5A} one clock after the read request
    always @(posedge clk) begin
        if (rd_en) begin
            din_r <= rd_addr[7:0];
            din_g <= rd_addr[7:0] ^ 8'hFF;
            din_b <= 8'h5A;
        end
    end

    int n_pass  = 0;
    int n_total = 0;
    int n       = 0;
    int n_ack   = 0;
    logic [8:0] h0 = '0;
    logic [8:0] h1 = '0;
    logic [8:0] h2 = '0;

    typedef struct {
        int         n;
        logic       rd_en;
        int         addr;
        logic       de;
        logic [7:0] r;
        logic       hs;
        logic       vs;
        logic       fs;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (n=%0d)", name, act, exp, n);
    endtask

    // One clock; sample on the falling edge and keep a short read history
    task tick();
        @(posedge clk);
        @(negedge clk);
        n++;
        if (swap_ack) n_ack++;
        h2 = h1;
        h1 = h0;
        h0 = {rd_en, rd_addr[7:0]};
    endtask

    task run_to(input int target);
        while (n < target) tick();
    endtask

    task check_all_zero(input string tag);
        check({tag, ".rd_addr"},  32'(rd_addr),  32'd0);
        check({tag, ".rd_en"},    32'(rd_en),    32'd0);
        check({tag, ".rd_sel"},   32'(rd_sel),   32'd0);
        check({tag, ".swap_ack"}, 32'(swap_ack), 32'd0);
        check({tag, ".fs"},       32'(fs),       32'd0);
        check({tag, ".pix_rgb"},  32'({pix_r, pix_g, pix_b}), 32'd0);
        check({tag, ".pix_de"},   32'(pix_de),   32'd0);
        check({tag, ".hsync"},    32'(hsync),    32'd0);
        check({tag, ".vsync"},    32'(vsync),    32'd0);
    endtask

    initial begin
        int de_cnt, rden_cnt, hs_cnt, vs_cnt, vs_run, vs_max, fs_cnt, data_err, fs_err;
        logic prev_de;
        logic [7:0] eg;
        logic [7:0] eb;

        // {n, rd_en, addr, de, pix_r, hsync, vsync, frame_start}; n = edges since enable
        vecs.push_back('{1,   1'b1, 0,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{2,   1'b1, 1,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3,   1'b1, 2,  1'b1, 8'h00, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{4,   1'b1, 3,  1'b1, 8'h01, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{10,  1'b1, 9,  1'b1, 8'h07, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{11,  1'b0, 0,  1'b1, 8'h08, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{12,  1'b0, 0,  1'b1, 8'h09, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{13,  1'b0, 0,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{14,  1'b0, 0,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{15,  1'b0, 0,  1'b0, 8'h00, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{17,  1'b0, 0,  1'b0, 8'h00, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{18,  1'b0, 0,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{19,  1'b1, 10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{21,  1'b1, 12, 1'b1, 8'h0A, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{163, 1'b1, 90, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{172, 1'b1, 99, 1'b1, 8'h61, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{173, 1'b0, 0,  1'b1, 8'h62, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{174, 1'b0, 0,  1'b1, 8'h63, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{175, 1'b0, 0,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{181, 1'b0, 0,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{200, 1'b0, 0,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{201, 1'b0, 0,  1'b0, 8'h00, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{213, 1'b0, 0,  1'b0, 8'h00, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{236, 1'b0, 0,  1'b0, 8'h00, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{237, 1'b0, 0,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{253, 1'b1, 0,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{255, 1'b1, 2,  1'b1, 8'h00, 1'b0, 1'b0, 1'b1});

        // Reset state
        rst = 1'b1;
        en = 1'b0;
        swap_req = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        // Start scanning
        rst = 1'b0;
        en = 1'b1;
        n = 0;
        foreach (vecs[i]) begin
            run_to(vecs[i].n);
            eg = vecs[i].de ? ~vecs[i].r : 8'h00;
            eb = vecs[i].de ? 8'h5A : 8'h00;
            check($sformatf("v%0d.rd_en", vecs[i].n), 32'(rd_en), 32'(vecs[i].rd_en));
            if (vecs[i].rd_en)
                check($sformatf("v%0d.rd_addr", vecs[i].n), 32'(rd_addr), 32'(vecs[i].addr));
            check($sformatf("v%0d.pix_de", vecs[i].n), 32'(pix_de), 32'(vecs[i].de));
            check($sformatf("v%0d.pix_r", vecs[i].n), 32'(pix_r), 32'(vecs[i].r));
            check($sformatf("v%0d.pix_g", vecs[i].n), 32'(pix_g), 32'(eg));
            check($sformatf("v%0d.pix_b", vecs[i].n), 32'(pix_b), 32'(eb));
            check($sformatf("v%0d.hsync", vecs[i].n), 32'(hsync), 32'(vecs[i].hs));
            check($sformatf("v%0d.vsync", vecs[i].n), 32'(vsync), 32'(vecs[i].vs));
            check($sformatf("v%0d.fs", vecs[i].n), 32'(fs), 32'(vecs[i].fs));
        end

        // One full 252-clock window of output statistics
        de_cnt = 0; rden_cnt = 0; hs_cnt = 0; vs_cnt = 0; vs_run = 0; vs_max = 0;
        fs_cnt = 0; data_err = 0; fs_err = 0;
        prev_de = pix_de;
        for (int k = 0; k < 252; k++) begin
            tick();
            if (pix_de) de_cnt++;
            if (rd_en) rden_cnt++;
            if (hsync) hs_cnt++;
            if (fs) fs_cnt++;
            if (vsync) begin
                vs_cnt++;
                vs_run++;
                if (vs_run > vs_max) vs_max = vs_run;
            end else begin
                vs_run = 0;
            end
            if (pix_de) begin
                if (!h2[8] || pix_r !== h2[7:0] || pix_g !== ~pix_r || pix_b !== 8'h5A) data_err++;
            end else if ({pix_r, pix_g, pix_b} !== 24'h0) begin
                data_err++;
            end
            if (fs && !(pix_de && !prev_de)) fs_err++;
            prev_de = pix_de;
        end
        check("win.de_count",   32'(de_cnt),   32'd100);
        check("win.rden_count", 32'(rden_cnt), 32'd100);
        check("win.hs_count",   32'(hs_cnt),   32'd42);
        check("win.vs_count",   32'(vs_cnt),   32'd36);
        check("win.vs_run",     32'(vs_max),   32'd36);
        check("win.fs_count",   32'(fs_cnt),   32'd1);
        check("win.data_err",   32'(data_err), 32'd0);
        check("win.fs_align",   32'(fs_err),   32'd0);

        // Swap requested mid-frame (h=5, v=3), repeated later in the same frame
        run_to(563);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("swap.sel_hold_a", 32'(rd_sel), 32'd0);
        run_to(604);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        run_to(755);
        check("swap.sel_hold_b", 32'(rd_sel), 32'd0);
        check("swap.ack_early",  32'(swap_ack), 32'd0);
        tick();
        check("swap.sel_toggle", 32'(rd_sel), 32'd1);
        check("swap.ack_pulse",  32'(swap_ack), 32'd1);
        tick();
        check("swap.ack_clear",  32'(swap_ack), 32'd0);
        run_to(1008);
        check("swap.no_extra_sel", 32'(rd_sel), 32'd1);
        check("swap.ack_total",    32'(n_ack), 32'd1);

        // Request on the last frame cycle (h=17, v=13) swaps immediately
        run_to(1259);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("bswap.sel", 32'(rd_sel), 32'd0);
        check("bswap.ack", 32'(swap_ack), 32'd1);
        run_to(1512);
        check("bswap.sel_next",  32'(rd_sel), 32'd0);
        check("bswap.no_pend",   32'(n_ack), 32'd2);

        // Pending swap survives a disable at h=4, v=2
        run_to(1530);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        run_to(1552);
        check("dis.rd_en_before", 32'(rd_en), 32'd1);
        en = 1'b0;
        tick();
        check("dis.rd_en_off", 32'(rd_en), 32'd0);
        tick();
        tick();
        check("dis.pix_de_off", 32'(pix_de), 32'd0);
        check("dis.pix_zero",   32'({pix_r, pix_g, pix_b}), 32'd0);
        tick();
        tick();
        check("dis.rd_en_hold", 32'(rd_en), 32'd0);
        check("dis.sel_hold",   32'(rd_sel), 32'd0);
        check("dis.no_ack",     32'(n_ack), 32'd2);
        en = 1'b1;
        n = 0;
        tick();
        check("reen.rd_en",  32'(rd_en), 32'd1);
        check("reen.addr0",  32'(rd_addr), 32'd0);
        check("reen.sel",    32'(rd_sel), 32'd0);
        tick();
        check("reen.addr1",  32'(rd_addr), 32'd1);
        tick();
        check("reen.fs",     32'(fs), 32'd1);
        check("reen.pix_de", 32'(pix_de), 32'd1);
        run_to(251);
        check("reen.sel_mid", 32'(rd_sel), 32'd0);
        tick();
        check("reen.sel_swap", 32'(rd_sel), 32'd1);
        check("reen.ack",      32'(swap_ack), 32'd1);

        // Asynchronous reset between edges at h=7, v=5
        run_to(349);
        check("arst.pix_de_before", 32'(pix_de), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("arst");
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        tick();
        check("arst.rd_en",  32'(rd_en), 32'd1);
        check("arst.addr0",  32'(rd_addr), 32'd0);
        tick();
        check("arst.addr1",  32'(rd_addr), 32'd1);
        tick();
        check("arst.fs",     32'(fs), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Read-side scan controller that sits directly downstream of the pixel frame buffers (buffer 1 / buffer 2).
- Generates raster timing (h/v counters, hsync, vsync, data-enable) and issues one read address per active pixel.
- Captures the 24-bit RGB byte triplet the selected buffer returns and drives a pipeline-aligned pixel stream to the display interface.
- Owns the frame-boundary swap between the two buffers.

Parameters:
- H_ACTIVE, 10, active pixels per line
- H_FP, 2, horizontal front porch (clocks)
- H_SYNC, 3, hsync width (clocks)
- H_BP, 3, horizontal back porch (clocks)
- V_ACTIVE, 10, active lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 1, vertical back porch (lines)
- ADDR_W, 20, read-address width

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- enable  in  1  scan enable; low forces idle
- swap_req  in  1  one-cycle pulse requesting buffer swap at next frame end
- din_b  in  8  buffer read byte [7:0]
- din_g  in  8  buffer read byte [15:8]
- din_r  in  8  buffer read byte [23:16]
- rd_addr  out  ADDR_W  buffer read address
- rd_en  out  1  buffer read enable
- rd_sel  out  1  0 = read buffer 1, 1 = read buffer 2
- swap_ack  out  1  one-cycle pulse when rd_sel toggles
- frame_start  out  1  one-cycle pulse, aligned with first pixel of a frame
- pix_r / pix_g / pix_b  out  8 each  pixel colour
- pix_de  out  1  active-video enable
- hsync  out  1  active-high horizontal sync
- vsync  out  1  active-high vertical sync

Behaviour:
- H_TOTAL = sum of the H_* parameters (default 18); V_TOTAL = sum of the V_* parameters (default 14); frame = 252 clocks. Counters are 12 bits.
- Stage 0: h_cnt counts 0..H_TOTAL-1. v_cnt increments when h_cnt wraps and counts 0..V_TOTAL-1.
  - active = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE)
  - hs0 = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); default [12,15)
  - vs0 = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC); default lines [11,13), full lines
- Stage 1 (registered): rd_en <= active; rd_addr <= pixel address. Address register:
  - cleared at h=0, v=0;
  - incremented after each active pixel, so it equals v*H_ACTIVE+h with no multiplier;
  - last address is H_ACTIVE*V_ACTIVE-1 (99).
- Stage 2: the buffer returns din_* one clock after rd_en/rd_addr.
- Stage 3 (registered): pix_* <= din_* when delayed active, else 0.
- de, hsync, vsync and frame_start are delayed through a 3-stage shift so they align with pix_*. Counter-to-pixel latency is 3 clocks.
- Swap handling:
  - swap_req sets swap_pend.
  - On the last stage-0 cycle of a frame (h=H_TOTAL-1, v=V_TOTAL-1), if swap_pend or swap_req: rd_sel toggles, swap_ack pulses 1 clock, swap_pend clears.
  - swap_req while already pending: no extra effect.
  - rd_sel never changes mid-frame.
- enable low (sampled each clock):
  - next cycle h_cnt=v_cnt=0, address=0, rd_en=0;
  - pipeline flushes zeros within 3 clocks;
  - swap_pend and rd_sel are held.
- enable re-asserted: the scan restarts at h=0, v=0, and frame_start appears 3 clocks later.
- Reset (async, any time): counters, address, swap_pend, rd_sel, rd_en, swap_ack, frame_start, pix_*, pix_de, hsync and vsync all go to 0 immediately.
- First scan cycle is the first clock after reset deasserts with enable=1.

Decomposition:
- Shared package holds:
  - timing defaults and derived H_TOTAL/V_TOTAL;
  - the RGB byte-lane mapping (B=[7:0], G=[15:8], R=[23:16]);
  - ADDR_W.
- One sub-module is natural: raster_timing_gen, which holds the h/v counters, active flag and sync decode.
- The pixel address, swap logic and the 3-stage align pipeline stay in the top module.

Test Plan:
- Reset, then enable=1 with the buffer model returning din = {addr[7:0], addr[7:0]^8'hFF, 8'h5A}:
  - rd_addr steps 0..9 in line 0 and 90..99 in line 9;
  - pix_de high for exactly 100 clocks per 252-clock frame;
  - pix_r equals the address issued 2 clocks earlier.
- Sync timing:
  - hsync high exactly at h=12..14, delayed 3 clocks;
  - vsync high for 36 consecutive clocks covering lines 11..12;
  - frame_start pulses once every 252 clocks, coincident with the first pix_de.
- Swap: swap_req at h=5, v=3.
  - rd_sel stays 0 through the frame;
  - toggles to 1 at frame end with a one-clock swap_ack;
  - a second swap_req in the same frame produces no extra toggle.
- Boundary swap: swap_req exactly on h=17, v=13 -> immediate toggle and ack, swap_pend left 0.
- enable dropped at h=4, v=2:
  - rd_en low the next clock;
  - pix_de low within 3 clocks;
  - on re-enable, rd_addr restarts at 0 and rd_sel is unchanged.
- Async reset asserted mid-line (h=7, v=5) between clock edges:
  - all outputs read 0 before the next edge;
  - after release the scan restarts at address 0.
